seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Frame scheduler that shares one serial 110101 sequence detector between NREQ byte-stream requesters.
- Arbitrates round-robin at frame granularity and serializes the granted frame's bytes MSB-first onto the detector input.
- Flushes the detector with zero bits between frames, so no match spans two frames.
- Counts the detector hits belonging to each frame and returns {source, count} on a result handshake.

Parameters:
- NREQ, 2: number of requesters.
- SRC_W, 1: source-id width; NREQ <= 2**SRC_W.
- FLUSH_LEN, 3: zero bits driven after each frame; minimum legal value 2.
- CNT_W, 8: hit-counter width; the counter saturates.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_data, in, NREQ*8: byte per requester; requester i uses bits [8i+7:8i].
- req_last, in, NREQ: byte is the last of its frame.
- req_valid, in, NREQ: byte valid.
- req_ready, out, NREQ: byte accepted when valid&ready; at most one bit set.
- det_bit, out, 1: registered serial bit to the detector data input.
- det_bit_vld, out, 1: registered; det_bit is frame data (0 for flush/idle/stall bits).
- det_hit, in, 1: detector match output; high the cycle after the final pattern bit is driven.
- res_valid, out, 1: frame result valid.
- res_src, out, SRC_W: requester index of the reported frame.
- res_count, out, CNT_W: hits detected in the frame.
- res_ready, in, 1: result accepted when valid&ready.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer 0; hit counter 0; hit window 0.
- Reset mid-frame aborts the frame without a result. Partially accepted frame bytes are lost.
- The detector sees det_bit every clk. It has no enable, so every idle, stall and flush cycle drives det_bit=0.
- IDLE:
  - Grant goes to the first requester with req_valid, searching from the rr pointer upward with wrap.
  - req_ready[grant] is asserted combinationally in the same cycle.
  - On handshake: load byte and last into the shift register, latch grant, clear the hit counter, go SHIFT.
- SHIFT:
  - Drives byte bits 7..0, one per cycle; det_bit_vld=1.
  - bit_cnt runs 0..7.
  - At bit_cnt==7 with last=0: req_ready[grant]=1. If valid, load the next byte and stay in SHIFT with no bubble. Otherwise go WAIT.
  - At bit_cnt==7 with last=1: go FLUSH.
- WAIT:
  - det_bit=0, det_bit_vld=0; req_ready[grant]=1.
  - On handshake, go SHIFT.
  - Stall zeros do enter the detector, so a pattern split across a stall is not detected. This is required behaviour.
- FLUSH: FLUSH_LEN cycles of det_bit=0, det_bit_vld=0, then go REPORT.
- REPORT:
  - res_valid=1; res_src=grant; res_count=counter.
  - res_* are held stable until res_ready.
  - On handshake: rr pointer = grant+1 (mod NREQ), go IDLE.
  - No new grant is issued while in REPORT.
- Hit counting:
  - hit_win is det_bit_vld delayed by one cycle.
  - The counter increments when det_hit & hit_win, saturating at 2**CNT_W-1.
  - A hit produced by the last frame bit lands in FLUSH cycle 1 and is counted.
  - Hits outside the window are ignored.
- Grant stays fixed for the whole frame. Other requesters' req_valid is ignored until IDLE.
- Non-granted req_ready bits are always 0.

Test Plan:
- req0 sends single-byte frame 0xD5 (last=1) -> det_bit 1,1,0,1,0,1,0,1 with det_bit_vld=1 for 8 cycles, then 3 zero cycles; res_src=0, res_count=1.
- req0 sends frame 0x03, 0x50 back-to-back -> 16 contiguous vld bits, no bubble; the cross-byte match gives res_count=1.
- Same frame with req_valid low for 2 cycles between the bytes -> 2 WAIT zero bits; res_count=0.
- req0 and req1 both present 0xD5 frames after reset -> req0 served first, then req1; results (0,1) then (1,1); next contention grants req0 again.
- With CNT_W=2, req1 sends five bytes 0x35 with the last flag on the fifth -> res_count=3 (saturated); res_valid is held 4 cycles with res_ready=0 and res_* stay stable.
- rst_n pulsed low during SHIFT of byte 2 -> all outputs 0 and busy=0 immediately; no result is issued; the next frame reports normally.

Source files
------------

// File: rtl/seq_det_sched.sv
// Shares one serial 110101 detector between NREQ byte-stream requesters: frame-level
// round-robin grants, MSB-first serialization, zero flush between frames, per-frame hit count.
module seq_det_sched #(
    parameter int NREQ      = 2,
    parameter int SRC_W     = 1,
    parameter int FLUSH_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ*8-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    output logic                 det_bit,
    output logic                 det_bit_vld,
    input  logic                 det_hit,
    output logic                 res_valid,
    output logic [SRC_W-1:0]     res_src,
    output logic [CNT_W-1:0]     res_count,
    input  logic                 res_ready,
    output logic                 busy
);
    localparam int FL_W = $clog2(FLUSH_LEN);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT, S_FLUSH, S_REPORT} state_t;

    state_t            r_state;
    logic [SRC_W-1:0]  r_rr;
    logic [SRC_W-1:0]  r_grant;
    logic [6:0]        r_sh;
    logic              r_last;
    logic [2:0]        r_bit_cnt;
    logic [FL_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_hit_win;
    logic              r_det_bit;
    logic              r_det_vld;
    logic              r_res_valid;

    logic [SRC_W-1:0]  w_gnt;
    logic              w_any;
    int                w_idx;
    logic [SRC_W-1:0]  w_sel;
    logic              w_take;
    logic              w_hs;
    logic [7:0]        w_byte;
    logic              w_byte_last;

    // First valid requester at or above the rr pointer, wrapping.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_rr) + k) % NREQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = SRC_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_sel = (r_state == S_IDLE) ? w_gnt : r_grant;
        case (r_state)
            S_IDLE:  w_take = w_any;
            S_SHIFT: w_take = (r_bit_cnt == 3'd7) && !r_last;
            S_WAIT:  w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
        w_take = w_take && rst_n;
    end

    assign w_hs        = w_take && req_valid[w_sel];
    assign w_byte      = req_data[8*int'(w_sel) +: 8];
    assign w_byte_last = req_last[w_sel];
    assign req_ready   = w_take ? (NREQ'(1) << w_sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_grant     <= '0;
            r_sh        <= '0;
            r_last      <= 1'b0;
            r_bit_cnt   <= '0;
            r_flush_cnt <= '0;
            r_det_bit   <= 1'b0;
            r_det_vld   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            // NOTE: these defaults are non-blocking too, so any later assignment in this block wins.
            r_det_bit <= 1'b0;
            r_det_vld <= 1'b0;
            if (w_hs) begin
                r_sh      <= w_byte[6:0];
                r_last    <= w_byte_last;
                r_grant   <= w_sel;
                r_bit_cnt <= '0;
                r_det_bit <= w_byte[7];
                r_det_vld <= 1'b1;
                r_state   <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_bit_cnt != 3'd7) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_sh      <= {r_sh[5:0], 1'b0};
                            r_det_bit <= r_sh[6];
                            r_det_vld <= 1'b1;
                        end else if (r_last) begin
                            r_flush_cnt <= '0;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_FLUSH: begin
                        if (r_flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                            r_res_valid <= 1'b1;
                            r_state     <= S_REPORT;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_rr        <= SRC_W'((int'(r_grant) + 1) % NREQ);
                            r_state     <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A hit arrives one cycle after its last bit, so the window is the delayed valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hit_win <= 1'b0;
        end else begin
            r_hit_win <= r_det_vld;
            if (w_hs && r_state == S_IDLE)
                r_cnt <= '0;
            else if (det_hit && r_hit_win && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign det_bit     = r_det_bit;
    assign det_bit_vld = r_det_vld;
    assign res_valid   = r_res_valid;
    assign res_src     = r_grant;
    assign res_count   = r_cnt;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: a 110101 detector stand-in, directed vector table, hand
// sequences for trace/contention/reset, and randomized frames against a bit-stream model.
module tb_seq_det_sched;
    localparam int NREQ      = 2;
    localparam int SRC_W     = 1;
    localparam int FLUSH_LEN = 3;
    localparam int CNT_W     = 2;
    localparam int SAT       = (1 << CNT_W) - 1;
    localparam int HS_LIMIT  = 400;
    localparam int RES_LIMIT = 400;

    logic               clk;
    logic               rst_n;
    logic [NREQ*8-1:0]  req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic               det_bit;
    logic               det_bit_vld;
    logic               det_hit;
    logic               res_valid;
    logic [SRC_W-1:0]   res_src;
    logic [CNT_W-1:0]   res_count;
    logic               res_ready;
    logic               busy;

    logic [7:0] tb_data  [NREQ];
    logic       tb_last  [NREQ];
    logic       tb_valid [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_data[8*i +: 8] = tb_data[i];
            req_last[i]        = tb_last[i];
            req_valid[i]       = tb_valid[i];
        end
    end

    seq_det_sched #(
        .NREQ(NREQ), .SRC_W(SRC_W), .FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
        .det_bit(det_bit), .det_bit_vld(det_bit_vld), .det_hit(det_hit),
        .res_valid(res_valid), .res_src(res_src), .res_count(res_count), .res_ready(res_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector: sees det_bit every clock, hit is high the cycle after the final pattern bit.
    logic [5:0] det_hist;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_hist <= '0;
        else        det_hist <= {det_hist[4:0], det_bit};
    end
    assign det_hit = (det_hist == 6'b110101);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int vld_tot  = 0;
    int run_len  = 0;
    int last_run = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", $countones(req_ready) <= 1, 1);
            if (!det_bit_vld) check("nonvld_bit_zero", det_bit, 0);
        end
        if (det_bit_vld) begin
            vld_tot++;
            run_len++;
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    typedef struct {
        int src;
        int cnt;
        int hold;
    } res_t;

    typedef struct {
        int         src;
        int         n;
        logic [7:0] b [5];
        int         gap1;
        int         hold;
        int         exp_cnt;
    } vec_t;

    res_t       exp_q[$];
    int         rr_model = 0;
    logic [7:0] fb   [NREQ][8];
    int         fgap [NREQ][8];
    int         flen [NREQ];

    function automatic vec_t mk(input int src, input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                                input int gap1, input int hold, input int exp_cnt);
        vec_t v;
        v.src = src; v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.gap1 = gap1; v.hold = hold; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    // The stream a frame puts on the wire: its bytes MSB-first with one zero per stall cycle.
    // Every 110101 occurrence ends on a data 1, so each one is an in-window hit.
    function automatic int model_count(input int r);
        logic stream[$];
        logic [5:0] win;
        int n;
        n = 0;
        win = '0;
        for (int j = 0; j < flen[r]; j++) begin
            if (j > 0) for (int g = 0; g < fgap[r][j]; g++) stream.push_back(1'b0);
            for (int b = 7; b >= 0; b--) stream.push_back(fb[r][j][b]);
        end
        foreach (stream[i]) begin
            win = {win[4:0], stream[i]};
            if (win == 6'b110101) n++;
        end
        return (n > SAT) ? SAT : n;
    endfunction

    task automatic push_exp(input int src, input int cnt, input int hold);
        res_t e;
        e.src = src; e.cnt = cnt; e.hold = hold;
        exp_q.push_back(e);
        rr_model = (src + 1) % NREQ;
    endtask

    task automatic wait_hs(input int r);
        bit ok;
        int t;
        ok = 1'b0;
        t = 0;
        while (!ok && t < HS_LIMIT) begin
            @(negedge clk);
            ok = req_ready[r] && tb_valid[r];
            @(posedge clk);
            t++;
        end
        #1;
        check("hs_timeout", ok, 1);
    endtask

    task automatic drive(input int r);
        for (int j = 0; j < flen[r]; j++) begin
            if (j > 0 && fgap[r][j] > 0) begin
                tb_valid[r] = 1'b0;
                repeat (7 + fgap[r][j]) @(posedge clk);
                #1;
            end
            tb_data[r]  = fb[r][j];
            tb_last[r]  = (j == flen[r] - 1);
            tb_valid[r] = 1'b1;
            wait_hs(r);
        end
        tb_valid[r] = 1'b0;
        tb_last[r]  = 1'b0;
    endtask

    task automatic collect(input int n);
        res_t e;
        bit ok;
        int t;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            ok = 1'b0;
            t = 0;
            while (!ok && t < RES_LIMIT) begin
                @(negedge clk);
                ok = res_valid;
                t++;
            end
            check("res_timeout", ok, 1);
            if (!ok) return;
            check("res_src", res_src, e.src);
            check("res_count", res_count, e.cnt);
            repeat (e.hold) begin
                @(negedge clk);
                check("hold_valid", res_valid, 1);
                check("hold_src", res_src, e.src);
                check("hold_count", res_count, e.cnt);
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            check("res_drop", res_valid, 0);
        end
    endtask

    task automatic run_round();
        int n;
        n = exp_q.size();
        @(posedge clk);
        #1;
        fork
            drive(0);
            drive(1);
            collect(n);
        join
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_det_bit"}, det_bit, 0);
        check({tag, "_det_vld"}, det_bit_vld, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_src"}, res_src, 0);
        check({tag, "_res_count"}, res_count, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    vec_t       vecs [6];
    logic [7:0] pat;
    int         tot0;
    bit         seen;
    bit         act [NREQ];
    int         start;

    initial begin
        vecs[0] = mk(0, 1, 8'hD5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        vecs[1] = mk(0, 2, 8'h03, 8'h50, 8'h00, 8'h00, 8'h00, 0, 1, 1);
        vecs[2] = mk(0, 2, 8'h03, 8'h50, 8'h00, 8'h00, 8'h00, 2, 0, 0);
        vecs[3] = mk(0, 2, 8'h03, 8'hA0, 8'h00, 8'h00, 8'h00, 1, 0, 1);
        vecs[4] = mk(1, 5, 8'h35, 8'h35, 8'h35, 8'h35, 8'h35, 0, 4, 3);
        vecs[5] = mk(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 0);

        rst_n     = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            tb_data[i] = '0; tb_last[i] = 1'b0; tb_valid[i] = 1'b0; flen[i] = 0;
        end
        #3 check_quiet("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_rst");

        // Single-byte frame 0xD5: bit-exact trace, flush length and report timing.
        @(posedge clk);
        #1;
        pat = 8'hD5;
        tb_data[0] = pat; tb_last[0] = 1'b1; tb_valid[0] = 1'b1;
        @(negedge clk);
        check("idle_ready0", req_ready[0], 1);
        check("idle_ready1", req_ready[1], 0);
        @(posedge clk);
        #1 tb_valid[0] = 1'b0;
        tb_last[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("d5_bit", det_bit, pat[7-k]);
            check("d5_vld", det_bit_vld, 1);
        end
        for (int k = 0; k < FLUSH_LEN; k++) begin
            @(negedge clk);
            check("flush_vld", det_bit_vld, 0);
            check("flush_res_valid", res_valid, 0);
            check("flush_busy", busy, 1);
        end
        @(negedge clk);
        check("d5_res_valid", res_valid, 1);
        check("d5_res_src", res_src, 0);
        check("d5_res_count", res_count, 1);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("d5_done_valid", res_valid, 0);
        check("d5_done_busy", busy, 0);
        rr_model = 1;

        foreach (vecs[v]) begin
            for (int i = 0; i < NREQ; i++) flen[i] = 0;
            flen[vecs[v].src] = vecs[v].n;
            for (int j = 0; j < vecs[v].n; j++) begin
                fb[vecs[v].src][j]   = vecs[v].b[j];
                fgap[vecs[v].src][j] = (j == 1) ? vecs[v].gap1 : 0;
            end
            push_exp(vecs[v].src, vecs[v].exp_cnt, vecs[v].hold);
            tot0 = vld_tot;
            run_round();
            check("vec_vld_bits", vld_tot - tot0, 8 * vecs[v].n);
            if (vecs[v].gap1 == 0) check("vec_no_bubble", last_run, 8 * vecs[v].n);
        end

        // Reset in the middle of the second byte of a frame.
        @(posedge clk);
        #1;
        tb_data[0] = 8'h03; tb_last[0] = 1'b0; tb_valid[0] = 1'b1;
        wait_hs(0);
        tb_data[0] = 8'h50;
        wait_hs(0);
        tb_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1 check_quiet("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("no_result_after_rst", seen, 0);
        rr_model = 0;

        // Contention after reset: requester 0 first, then 1, and 0 wins the next contention.
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < NREQ; i++) begin
                flen[i] = 1; fb[i][0] = 8'hD5; fgap[i][0] = 0;
            end
            push_exp(0, 1, 0);
            push_exp(1, 1, 1);
            run_round();
        end

        for (int round = 0; round < 40; round++) begin
            for (int i = 0; i < NREQ; i++) begin
                act[i] = ($urandom_range(0, 2) != 0);
                flen[i] = 0;
            end
            if (!act[0] && !act[1]) act[0] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (act[i]) begin
                    flen[i] = $urandom_range(1, 4);
                    for (int j = 0; j < flen[i]; j++) begin
                        case ($urandom_range(0, 3))
                            0:       fb[i][j] = 8'h35;
                            1:       fb[i][j] = 8'hD5;
                            2:       fb[i][j] = 8'h6B;
                            default: fb[i][j] = 8'($urandom);
                        endcase
                        fgap[i][j] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
                    end
                end
            end
            start = rr_model;
            for (int k = 0; k < NREQ; k++) begin
                if (act[(start + k) % NREQ])
                    push_exp((start + k) % NREQ, model_count((start + k) % NREQ), $urandom_range(0, 2));
            end
            run_round();
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
